// File: rtl/hamming_secded_dec_pipe_if.sv
// rtl/hamming_secded_dec_pipe_if.sv - codeword-in / result-out stream bundle for the SECDED decoder
interface hamming_secded_dec_pipe_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16
);
  // Smallest r with 2^r >= DATA_W + r + 1.
  function automatic int calc_par_w(input int dw);
    int r;
    r = 1;
    while ((1 << r) < dw + r + 1) r++;
    return r;
  endfunction

  localparam int PAR_W  = calc_par_w(DATA_W);
  localparam int CODE_W = DATA_W + PAR_W + 1;

  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in_code;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_corr;
  logic              out_uncorr;
  logic [PAR_W-1:0]  out_syn;
  logic              cnt_clr;
  logic [CNT_W-1:0]  cnt_corr;
  logic [CNT_W-1:0]  cnt_uncorr;

  modport master (
    output in_valid, in_code, out_ready, cnt_clr,
    input  in_ready, out_valid, out_data, out_corr, out_uncorr, out_syn,
           cnt_corr, cnt_uncorr
  );

  modport slave (
    input  in_valid, in_code, out_ready, cnt_clr,
    output in_ready, out_valid, out_data, out_corr, out_uncorr, out_syn,
           cnt_corr, cnt_uncorr
  );
endinterface

// File: rtl/hamming_secded_dec_pipe.sv
// rtl/hamming_secded_dec_pipe.sv - two-stage SECDED Hamming decoder, optional error counters via HAMMING_DEC_STATS_EN
module hamming_secded_dec_pipe #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16
) (
  input logic                      clk,
  input logic                      rst_n,
  hamming_secded_dec_pipe_if.slave bus
);
  function automatic int calc_par_w(input int dw);
    int r;
    r = 1;
    while ((1 << r) < dw + r + 1) r++;
    return r;
  endfunction

  // Hamming position (1-based) carrying data bit i: the i-th non-power-of-two position.
  function automatic int data_pos(input int i);
    int p;
    int n;
    p = 2;
    n = -1;
    while (n < i) begin
      p++;
      if ((p & (p - 1)) != 0) n++;
    end
    return p;
  endfunction

  localparam int PAR_W  = calc_par_w(DATA_W);
  localparam int CODE_W = DATA_W + PAR_W + 1;

  logic              s1_en, s2_en;
  logic              s1_valid_q, s2_valid_q;
  logic [CODE_W-2:0] code_q;
  logic [PAR_W-1:0]  syn1_q, syn1_d;
  logic              par_q, par_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              corr_q, corr_d, uncorr_q, uncorr_d;
  logic [PAR_W-1:0]  syn2_q;
  logic [CODE_W-2:0] flip, fixed;
  logic              in_range;

  assign s2_en        = !s2_valid_q || bus.out_ready;
  assign s1_en        = !s1_valid_q || s2_en;
  assign bus.in_ready = s1_en;

  // Syndrome and overall parity of the incoming codeword.
  always_comb begin
    syn1_d = '0;
    for (int k = 0; k < CODE_W - 1; k++) begin
      if (bus.in_code[k]) syn1_d = syn1_d ^ PAR_W'(k + 1);
    end
    par_d = ^bus.in_code;
  end

  // Stage 1: capture codeword, syndrome and parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      code_q     <= '0;
      syn1_q     <= '0;
      par_q      <= 1'b0;
    end else if (s1_en) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        code_q <= bus.in_code[CODE_W-2:0];
        syn1_q <= syn1_d;
        par_q  <= par_d;
      end
    end
  end

  // Syndromes past the last real position only occur in shortened codes and are uncorrectable.
  assign in_range = (32'(syn1_q) <= 32'(CODE_W - 1));

  // Classify, flip the addressed bit on a single error, then pull out the data positions.
  always_comb begin
    flip     = '0;
    data_d   = '0;
    corr_d   = par_q && in_range;
    uncorr_d = (syn1_q != '0 && !par_q) || (par_q && !in_range);
    for (int k = 0; k < CODE_W - 1; k++) begin
      flip[k] = par_q && (syn1_q == PAR_W'(k + 1));
    end
    fixed = code_q ^ flip;
    for (int i = 0; i < DATA_W; i++) begin
      data_d[i] = fixed[data_pos(i) - 1];
    end
  end

  // Stage 2: result register, frozen while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      data_q     <= '0;
      corr_q     <= 1'b0;
      uncorr_q   <= 1'b0;
      syn2_q     <= '0;
    end else if (s2_en) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        data_q   <= data_d;
        corr_q   <= corr_d;
        uncorr_q <= uncorr_d;
        syn2_q   <= syn1_q;
      end
    end
  end

  assign bus.out_valid  = s2_valid_q;
  assign bus.out_data   = data_q;
  assign bus.out_corr   = corr_q;
  assign bus.out_uncorr = uncorr_q;
  assign bus.out_syn    = syn2_q;

`ifdef HAMMING_DEC_STATS_EN
  logic [CNT_W-1:0] cnt_corr_q, cnt_corr_d, cnt_uncorr_q, cnt_uncorr_d;
  logic             out_xfer;

  assign out_xfer = s2_valid_q && bus.out_ready;

  // Saturating counters; a clear overrides any increment in the same cycle.
  always_comb begin
    cnt_corr_d   = cnt_corr_q;
    cnt_uncorr_d = cnt_uncorr_q;
    if (bus.cnt_clr) begin
      cnt_corr_d   = '0;
      cnt_uncorr_d = '0;
    end else if (out_xfer) begin
      if (corr_q && cnt_corr_q != '1)     cnt_corr_d   = cnt_corr_q + 1'b1;
      if (uncorr_q && cnt_uncorr_q != '1) cnt_uncorr_d = cnt_uncorr_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else begin
      cnt_corr_q   <= cnt_corr_d;
      cnt_uncorr_q <= cnt_uncorr_d;
    end
  end

  assign bus.cnt_corr   = cnt_corr_q;
  assign bus.cnt_uncorr = cnt_uncorr_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = bus.cnt_clr;
  assign bus.cnt_corr   = '0;
  assign bus.cnt_uncorr = '0;
`endif
endmodule

// File: tb/tb_hamming_secded_dec_pipe.sv
// tb/tb_hamming_secded_dec_pipe.sv - scoreboard bench for the pipelined SECDED decoder
module tb_hamming_secded_dec_pipe;
  localparam int DATA_W = 4;
`ifdef HAMMING_DEC_STATS_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hamming_secded_dec_pipe_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  hamming_secded_dec_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0] data;
    logic       corr;
    logic       uncorr;
    logic [2:0] syn;
    logic       chk_lat;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [7:0] code;
    logic [3:0] data;
    logic       corr;
    logic       uncorr;
    logic [2:0] syn;
  } vec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops expected results on each output transfer, checks stability while stalled.
  logic       held = 1'b0;
  logic [8:0] held_v;
  logic [8:0] cur;
  exp_t       e;
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else if (bus.out_valid) begin
      cur = {bus.out_data, bus.out_corr, bus.out_uncorr, bus.out_syn};
      if (held) chk("hold_stable", 64'(cur), 64'(held_v));
      if (bus.out_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_output: got %0h, expected no output", cur);
        end else begin
          e = sb.pop_front();
          chk("out_word", 64'(cur), 64'({e.data, e.corr, e.uncorr, e.syn}));
          if (e.chk_lat) chk("latency", 64'(cyc - e.cyc), 64'd2);
        end
        held = 1'b0;
      end else begin
        held   = 1'b1;
        held_v = cur;
      end
    end
  end

  task automatic send(input vec_t v, input logic lat);
    exp_t x;
    int   n;
    bus.in_valid = 1'b1;
    bus.in_code  = v.code;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 50) begin
        n_vec++;
        n_err++;
        $display("FAIL in_ready_timeout: got 0, expected 1 within 50 cycles");
        break;
      end
    end
    x.data = v.data; x.corr = v.corr; x.uncorr = v.uncorr; x.syn = v.syn;
    x.chk_lat = lat; x.cyc = cyc;
    sb.push_back(x);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_done", 64'(sb.size()), 64'd0);
  endtask

  vec_t vecs[8] = '{
    '{8'h55, 4'hB, 1'b0, 1'b0, 3'd0},
    '{8'h45, 4'hB, 1'b1, 1'b0, 3'd5},
    '{8'hD5, 4'hB, 1'b1, 1'b0, 3'd0},
    '{8'h56, 4'hB, 1'b0, 1'b1, 3'd3},
    '{8'h54, 4'hB, 1'b1, 1'b0, 3'd1},
    '{8'hFF, 4'hF, 1'b0, 1'b0, 3'd0},
    '{8'hDF, 4'hF, 1'b1, 1'b0, 3'd6},
    '{8'hEB, 4'hC, 1'b0, 1'b1, 3'd6}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_code  = '0;
    bus.out_ready = 1'b1;
    bus.cnt_clr  = 1'b0;
    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_bus", 64'({bus.out_data, bus.out_corr, bus.out_uncorr, bus.out_syn}), 64'd0);
    chk("rst_cnt", 64'({bus.cnt_corr, bus.cnt_uncorr}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Isolated words: each decoded with 2-cycle latency.
    for (int i = 0; i < 8; i++) begin
      send(vecs[i], 1'b1);
      drain();
    end

    // Back-to-back words with a 3-cycle consumer stall after the first result.
    fork
      begin
        send(vecs[0], 1'b0);
        send(vecs[1], 1'b0);
        send(vecs[3], 1'b0);
      end
      begin
        n = 0;
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (!bus.out_valid && n < 20);
        chk("stall_first_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("in_ready_full", 64'(bus.in_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with two words in flight.
    send(vecs[0], 1'b0);
    send(vecs[1], 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_out_bus", 64'({bus.out_data, bus.out_corr, bus.out_uncorr, bus.out_syn}), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst_cnt", 64'({bus.cnt_corr, bus.cnt_uncorr}), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(vecs[1], 1'b1);
    drain();

`ifdef HAMMING_DEC_STATS_EN
    bus.cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.cnt_clr = 1'b0;
    chk("cnt_clr_idle", 64'({bus.cnt_corr, bus.cnt_uncorr}), 64'd0);
    for (int i = 0; i < 5; i++) send(vecs[1], 1'b0);
    drain();
    chk("cnt_corr_sat", 64'(bus.cnt_corr), 64'd3);
    chk("cnt_uncorr_zero", 64'(bus.cnt_uncorr), 64'd0);
    send(vecs[3], 1'b1);
    drain();
    chk("cnt_uncorr_one", 64'(bus.cnt_uncorr), 64'd1);
    send(vecs[1], 1'b1);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    bus.cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.cnt_clr = 1'b0;
    chk("cnt_clr_wins", 64'(bus.cnt_corr), 64'd0);
    drain();
`else
    bus.cnt_clr = 1'b1;
    send(vecs[1], 1'b1);
    bus.cnt_clr = 1'b0;
    drain();
    chk("cnt_tied_zero", 64'({bus.cnt_corr, bus.cnt_uncorr}), 64'd0);
`endif

    repeat (3) @(posedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
